// File: rtl/shift_left_seq.sv
// Iterative left shifter / rotator: moves the operand one bit per clock and
// hands the result back through a valid/ready handshake. One op in flight.
module shift_left_seq #(
  parameter int N = 16,  // data width
  parameter int C = 4    // shift-count width, max shift 2^C-1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic         Rot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] acc;
  logic [C-1:0] remaining;
  logic         rot;
  logic         accept;

  // One-position left step: rotate feeds the MSB back in, shift fills zero.
  function automatic logic [N-1:0] step_left(input logic [N-1:0] v,
                                             input logic         r);
    return {v[N-2:0], (r ? v[N-1] : 1'b0)};
  endfunction

  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign in_ready  = ~busy;
  assign out_valid = (state == DONE);
  assign Out       = acc;

  // State register; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a zero count skips straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (Cnt == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining == C'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one shift step per SHIFT cycle.
  // acc is held in DONE and IDLE so Out keeps the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      rot       <= 1'b0;
    end else if (accept) begin
      acc       <= In;
      remaining <= Cnt;
      rot       <= Rot;
    end else if (state == SHIFT) begin
      acc       <= step_left(acc, rot);
      remaining <= remaining - C'(1);
    end
  end

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed bench for shift_left_seq: vector table plus corner-case sequences.
module tb_shift_left_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic        Rot;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_left_seq #(.N(16), .C(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .In(In), .Cnt(Cnt), .Rot(Rot),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  cnt;
    logic        rot;
    logic [15:0] exp;
    int          lat;  // rising edges after the accept edge until out_valid
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one request, wait for the result, check it, then consume it.
  task automatic run_op(input string name, input logic [15:0] din,
                        input logic [3:0] cnt, input logic r,
                        input logic [15:0] exp, input int exp_lat);
    int lat;
    check({name, " in_ready before"}, in_ready, 1);
    in_valid = 1'b1;
    In = din; Cnt = cnt; Rot = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // scramble operands: only the accept edge sample may matter
    In = ~din; Cnt = ~cnt; Rot = ~r;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " out_valid"}, out_valid, 1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " Out"}, Out, exp);
    check({name, " busy in DONE"}, busy, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid drop"}, out_valid, 0);
    check({name, " in_ready after"}, in_ready, 1);
    check({name, " Out kept in IDLE"}, Out, exp);
  endtask

  initial begin
    int lat;
    vecs[0] = '{16'h0001, 4'hF, 1'b0, 16'h8000, 15};
    vecs[1] = '{16'h8001, 4'h1, 1'b1, 16'h0003, 1};
    vecs[2] = '{16'h8001, 4'h1, 1'b0, 16'h0002, 1};
    vecs[3] = '{16'hA5A5, 4'h0, 1'b0, 16'hA5A5, 0};  // visible in first cycle after accept
    vecs[4] = '{16'hA5A5, 4'h4, 1'b1, 16'h5A5A, 4};
    vecs[5] = '{16'h1234, 4'h4, 1'b0, 16'h2340, 4};
    vecs[6] = '{16'h8000, 4'hF, 1'b1, 16'h4000, 15};
    vecs[7] = '{16'hFFFF, 4'hF, 1'b0, 16'h8000, 15};
    vecs[8] = '{16'h1234, 4'h8, 1'b1, 16'h3412, 8};
    vecs[9] = '{16'h00FF, 4'h8, 1'b0, 16'hFF00, 8};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    In = '0; Cnt = '0; Rot = 1'b0;
    #2;
    check("reset Out", Out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].cnt, vecs[i].rot,
             vecs[i].exp, vecs[i].lat);

    // Backpressure: result held, pending request ignored until IDLE.
    in_valid = 1'b1; In = 16'hFFFF; Cnt = 4'h4; Rot = 1'b0;
    @(posedge clk); #1;
    In = 16'h0003; Cnt = 4'h1; Rot = 1'b0;  // next request, held by source
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold out_valid %0d", k), out_valid, 1);
      check($sformatf("bp hold Out %0d", k), Out, 16'hFFF0);
      check($sformatf("bp hold in_ready %0d", k), in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle out_valid", out_valid, 0);
    check("bp idle in_ready", in_ready, 1);
    check("bp idle Out", Out, 16'hFFF0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp pending accepted busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp pending latency", lat, 1);
    check("bp pending Out", Out, 16'h0006);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-SHIFT discards the op.
    in_valid = 1'b1; In = 16'hFFFF; Cnt = 4'h8; Rot = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("midshift busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async reset Out", Out, 0);
    check("async reset out_valid", out_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("discarded op no out_valid %0d", k), out_valid, 0);
    end
    run_op("after reset", 16'h00FF, 4'h8, 1'b0, 16'hFF00, 8);

    // Reset while DONE with a nonzero result.
    in_valid = 1'b1; In = 16'h00F0; Cnt = 4'h0; Rot = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done before reset Out", Out, 16'h00F0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset in DONE Out", Out, 0);
    check("reset in DONE out_valid", out_valid, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule
